// File: rtl/enc_pkg.sv
// Shared types and helpers for the 4-to-2 request encoder.
package enc_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = $clog2(N_REQ);

    typedef logic [IDX_W-1:0] idx_t;

    // Decode an index back to a one-hot request mask.
    function automatic logic [N_REQ-1:0] onehot(idx_t idx);
        return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/enc_pick.sv
// Combinational request picker: returns the first set bit of req,
// scanning upward from start+1 and wrapping modulo N.
module enc_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W-1:0] pos;

    // Walk the scan order backwards so the earliest hit overwrites later ones.
    always_comb begin
        idx = '0;
        pos = '0;
        for (int i = N; i >= 1; i--) begin
            pos = start + W'(i);
            if (req[pos]) begin
                idx = pos;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/enc4x2_q.sv
// Registered 4-to-2 request encoder with sticky pending bits.
// Request strobes merge into a pending set; one index is presented per
// V/RDY handshake. Define ENC_ROUND_ROBIN_EN for rotating priority
// (scan starts after the last served index); otherwise index 0 always
// has highest priority and no pointer register exists.
module enc4x2_q
    import enc_pkg::*;
#(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic [N-1:0] R,
    output logic [W-1:0] A,
    output logic         V,
    input  logic         RDY,
    output logic         BUSY
);

    logic [N-1:0] pend;
    logic [N-1:0] pend_in;
    logic [N-1:0] clr_mask;
    logic [W-1:0] pick_idx;
    logic         pick_any;
    logic [W-1:0] start;
    logic         load;

    // New strobes are merged combinationally so they can load this cycle.
    always_comb begin
        pend_in = pend | (EN ? R : '0);
        load    = (!V || RDY) && pick_any;
    end

    assign clr_mask = onehot(idx_t'(pick_idx));

`ifdef ENC_ROUND_ROBIN_EN
    logic [W-1:0] ptr;

    // Remember the last served index so the next scan starts just after it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= pick_idx;
        end
    end

    assign start = ptr;
`else
    // Starting at N-1 makes the first scanned index 0: fixed priority.
    assign start = W'(N - 1);
`endif

    enc_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .req   (pend_in),
        .start (start),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Handshake: load a new index when the output slot is free or being
    // accepted; otherwise hold A/V and just accumulate requests.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend <= '0;
            A    <= '0;
            V    <= 1'b0;
        end else if (load) begin
            pend <= pend_in & ~clr_mask;
            A    <= pick_idx;
            V    <= 1'b1;
        end else begin
            pend <= pend_in;
            if (V && RDY) begin
                V <= 1'b0;
            end
        end
    end

    // Only requests still waiting behind the one on A count as busy.
    assign BUSY = |pend;

endmodule
